// File: rtl/morse_tx_word.sv
// morse_tx_word
//   Morse transmitter. Latches a word of character codes on start and keys
//   the signal line with each character's ITU dit/dah pattern, sending slot
//   len-1 first and slot 0 last. All timing counts ce pulses. The line
//   polarity matches the capture side (1 = space, 0 = mark), so the output
//   can be looped back into the decoder.
//
//   Character codes: 0 = blank, 1..26 = A..Z, 27..36 = digits 0..9,
//   37..63 = invalid. Blank and invalid characters send no mark; a word_time
//   gap stands in for them, and invalid ones also set the sticky error flag.
//
//   Optional feature (macro MORSE_TX_REPEAT_EN): adds input repeat_en
//   (the repeat request; "repeat" itself is a reserved word). While it is
//   high in DONE, the latched word is sent again without returning to IDLE.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   ce              clock enable; state and timer advance only when ce=1
//   dit_time        dit mark length and inter-element gap (ce pulses)
//   dah_time        dah mark length and inter-character gap
//   word_time       trailing word gap and the gap used for blank characters
//   start           send request, sampled in IDLE with ce=1
//   word            character codes, slot i at [i*CHAR_W +: CHAR_W]
//   len             characters to send, 1..MAX_CHARS
//   repeat_en       (MORSE_TX_REPEAT_EN only) resend after each pass
//   signal          keyed line, 1 = idle/space, 0 = mark
//   busy            transmission in progress
//   done            end-of-transmission pulse (one ce cycle)
//   error           sticky invalid code/len flag, cleared on accepted start
module morse_tx_word #(
    parameter int MAX_CHARS = 6,
    parameter int CHAR_W    = 6,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ce,
    input  logic [CNT_W-1:0]            dit_time,
    input  logic [CNT_W-1:0]            dah_time,
    input  logic [CNT_W-1:0]            word_time,
    input  logic                        start,
    input  logic [CHAR_W*MAX_CHARS-1:0] word,
    input  logic [2:0]                  len,
`ifdef MORSE_TX_REPEAT_EN
    input  logic                        repeat_en,
`endif
    output logic                        signal,
    output logic                        busy,
    output logic                        done,
    output logic                        error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARK,
        S_GAP_ELEM,
        S_GAP_CHAR,
        S_GAP_WORD,
        S_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            timer_q, timer_d;
    logic [2:0]                  idx_q, idx_d;
    logic [2:0]                  elem_q, elem_d;
    logic [CHAR_W*MAX_CHARS-1:0] word_q, word_d;
    logic                        error_q, error_d;
`ifdef MORSE_TX_REPEAT_EN
    logic [2:0]                  len_q, len_d;
`endif

    // Pattern ROM: {element count, 5 element bits left-aligned}, first
    // element in bit 4, 1 = dah. Count 0 marks blank/invalid codes.
    function automatic logic [7:0] rom(input logic [CHAR_W-1:0] c);
        case (c)
            6'd1:  rom = {3'd2, 5'b01000}; // A .-
            6'd2:  rom = {3'd4, 5'b10000}; // B -...
            6'd3:  rom = {3'd4, 5'b10100}; // C -.-.
            6'd4:  rom = {3'd3, 5'b10000}; // D -..
            6'd5:  rom = {3'd1, 5'b00000}; // E .
            6'd6:  rom = {3'd4, 5'b00100}; // F ..-.
            6'd7:  rom = {3'd3, 5'b11000}; // G --.
            6'd8:  rom = {3'd4, 5'b00000}; // H ....
            6'd9:  rom = {3'd2, 5'b00000}; // I ..
            6'd10: rom = {3'd4, 5'b01110}; // J .---
            6'd11: rom = {3'd3, 5'b10100}; // K -.-
            6'd12: rom = {3'd4, 5'b01000}; // L .-..
            6'd13: rom = {3'd2, 5'b11000}; // M --
            6'd14: rom = {3'd2, 5'b10000}; // N -.
            6'd15: rom = {3'd3, 5'b11100}; // O ---
            6'd16: rom = {3'd4, 5'b01100}; // P .--.
            6'd17: rom = {3'd4, 5'b11010}; // Q --.-
            6'd18: rom = {3'd3, 5'b01000}; // R .-.
            6'd19: rom = {3'd3, 5'b00000}; // S ...
            6'd20: rom = {3'd1, 5'b10000}; // T -
            6'd21: rom = {3'd3, 5'b00100}; // U ..-
            6'd22: rom = {3'd4, 5'b00010}; // V ...-
            6'd23: rom = {3'd3, 5'b01100}; // W .--
            6'd24: rom = {3'd4, 5'b10010}; // X -..-
            6'd25: rom = {3'd4, 5'b10110}; // Y -.--
            6'd26: rom = {3'd4, 5'b11000}; // Z --..
            6'd27: rom = {3'd5, 5'b11111}; // 0
            6'd28: rom = {3'd5, 5'b01111}; // 1
            6'd29: rom = {3'd5, 5'b00111}; // 2
            6'd30: rom = {3'd5, 5'b00011}; // 3
            6'd31: rom = {3'd5, 5'b00001}; // 4
            6'd32: rom = {3'd5, 5'b00000}; // 5
            6'd33: rom = {3'd5, 5'b10000}; // 6
            6'd34: rom = {3'd5, 5'b11000}; // 7
            6'd35: rom = {3'd5, 5'b11100}; // 8
            6'd36: rom = {3'd5, 5'b11110}; // 9
            default: rom = 8'd0;
        endcase
    endfunction

    // Timer counts down to zero, so a duration D loads D-1; 0 behaves as 1.
    function automatic logic [CNT_W-1:0] ld(input logic [CNT_W-1:0] t);
        ld = (t == '0) ? '0 : t - 1'b1;
    endfunction

    // Slot mux; an out-of-range index reads as blank.
    function automatic logic [CHAR_W-1:0] slot_sel(input logic [CHAR_W*MAX_CHARS-1:0] src,
                                                   input logic [2:0] idx);
        slot_sel = '0;
        for (int i = 0; i < MAX_CHARS; i++)
            if (idx == 3'(i)) slot_sel = src[i*CHAR_W +: CHAR_W];
    endfunction

    // Current character being keyed.
    logic [7:0] cur_rom;
    logic [2:0] cur_cnt;
    logic [4:0] cur_bits;
    logic       cur_bit;

    assign cur_rom  = rom(slot_sel(word_q, idx_q));
    assign cur_cnt  = cur_rom[7:5];
    assign cur_bits = cur_rom[4:0];
    assign cur_bit  = cur_bits[3'd4 - elem_q];

    // Character about to be entered: the first one on start (or repeat)
    // and the next lower slot otherwise.
    logic [2:0]                  ent_idx;
    logic [CHAR_W*MAX_CHARS-1:0] ent_src;
    logic [CHAR_W-1:0]           ent_char;
    logic [7:0]                  ent_rom;
    state_t                      ent_state;
    logic [CNT_W-1:0]            ent_timer;
    logic                        ent_err;

    always_comb begin
        ent_idx = idx_q - 3'd1;
        ent_src = word_q;
        if (state_q == S_IDLE) begin
            ent_idx = len - 3'd1;
            ent_src = word;
        end
`ifdef MORSE_TX_REPEAT_EN
        else if (state_q == S_DONE) begin
            ent_idx = len_q - 3'd1;
        end
`endif
    end

    assign ent_char = slot_sel(ent_src, ent_idx);
    assign ent_rom  = rom(ent_char);

    always_comb begin
        ent_state = S_MARK;
        ent_timer = ld(ent_rom[4] ? dah_time : dit_time);
        ent_err   = 1'b0;
        if (ent_rom[7:5] == 3'd0) begin
            // Blank or invalid: no mark, a word gap takes its place.
            ent_state = S_GAP_WORD;
            ent_timer = ld(word_time);
            ent_err   = (ent_char != '0);
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        elem_d  = elem_q;
        word_d  = word_q;
        error_d = error_q;
`ifdef MORSE_TX_REPEAT_EN
        len_d   = len_q;
`endif
        if (ce) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        word_d  = word;
                        error_d = 1'b0;
`ifdef MORSE_TX_REPEAT_EN
                        len_d   = len;
`endif
                        if (len == 3'd0 || int'(len) > MAX_CHARS) begin
                            error_d = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = ent_state;
                            timer_d = ent_timer;
                            idx_d   = ent_idx;
                            elem_d  = 3'd0;
                            if (ent_err) error_d = 1'b1;
                        end
                    end
                end
                S_MARK, S_GAP_ELEM, S_GAP_CHAR, S_GAP_WORD: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - 1'b1;
                    end else begin
                        case (state_q)
                            S_MARK: begin
                                if (elem_q + 3'd1 < cur_cnt) begin
                                    state_d = S_GAP_ELEM;
                                    timer_d = ld(dit_time);
                                    elem_d  = elem_q + 3'd1;
                                end else if (idx_q == 3'd0) begin
                                    state_d = S_GAP_WORD;
                                    timer_d = ld(word_time);
                                end else begin
                                    state_d = S_GAP_CHAR;
                                    timer_d = ld(dah_time);
                                end
                            end
                            S_GAP_ELEM: begin
                                // elem_q already points at the next element.
                                state_d = S_MARK;
                                timer_d = ld(cur_bit ? dah_time : dit_time);
                            end
                            default: begin
                                if (state_q == S_GAP_WORD && idx_q == 3'd0) begin
                                    state_d = S_DONE;
                                end else begin
                                    state_d = ent_state;
                                    timer_d = ent_timer;
                                    idx_d   = ent_idx;
                                    elem_d  = 3'd0;
                                    if (ent_err) error_d = 1'b1;
                                end
                            end
                        endcase
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
`ifdef MORSE_TX_REPEAT_EN
                    // Only a pass that actually ran (valid len) can repeat.
                    if (repeat_en && len_q != 3'd0 && int'(len_q) <= MAX_CHARS) begin
                        state_d = ent_state;
                        timer_d = ent_timer;
                        idx_d   = ent_idx;
                        elem_d  = 3'd0;
                        if (ent_err) error_d = 1'b1;
                    end
`endif
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            elem_q  <= '0;
            word_q  <= '0;
            error_q <= 1'b0;
`ifdef MORSE_TX_REPEAT_EN
            len_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            elem_q  <= elem_d;
            word_q  <= word_d;
            error_q <= error_d;
`ifdef MORSE_TX_REPEAT_EN
            len_q   <= len_d;
`endif
        end
    end

    assign signal = (state_q != S_MARK);
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign error  = error_q;

endmodule

// File: tb/tb_morse_tx_word.sv
module tb_morse_tx_word;

    logic        clk = 1'b0;
    logic        rst_n, ce, start;
    logic [15:0] dit_time, dah_time, word_time;
    logic [35:0] word;
    logic [2:0]  len;
    logic        signal, busy, done, error;

    morse_tx_word dut (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .dit_time(dit_time), .dah_time(dah_time), .word_time(word_time),
        .start(start), .word(word), .len(len),
`ifdef MORSE_TX_REPEAT_EN
        .repeat_en(1'b0),
`endif
        .signal(signal), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ITU patterns by code; index 0 is blank.
    string mtab [0:36] = '{"", ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
        "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...",
        "-", "..-", "...-", ".--", "-..-", "-.--", "--..", "-----", ".----", "..---",
        "...--", "....-", ".....", "-....", "--...", "---..", "----."};

    // Model state: expected line value per ce step, then one DONE step.
    bit exp_sig[$];
    int exp_n;
    bit exp_err;
    int sl[6];

    bit active = 0;
    int ptr, cyc, done_cyc, mark_clks;
    bit ce_toggle = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input bit v, input int n);
        for (int k = 0; k < n; k++) exp_sig.push_back(v);
    endtask

    task automatic build(input int l, input int d, input int dh, input int wt);
        exp_sig.delete();
        exp_err = 0;
        if (d == 0) d = 1;
        if (dh == 0) dh = 1;
        if (wt == 0) wt = 1;
        if (l < 1 || l > 6) exp_err = 1;
        else begin
            for (int i = l - 1; i >= 0; i--) begin
                int c;
                string p;
                c = sl[i];
                if (c == 0 || c > 36) begin
                    if (c > 36) exp_err = 1;
                    push(1, wt);
                end else begin
                    p = mtab[c];
                    for (int j = 0; j < p.len(); j++) begin
                        push(0, (p[j] == "-") ? dh : d);
                        if (j < p.len() - 1) push(1, d);
                        else push(1, (i == 0) ? wt : dh);
                    end
                end
            end
        end
        exp_n = exp_sig.size();
    endtask

    // Clock enable: steady 1, or toggling every clk when ce_toggle is set.
    always @(posedge clk) begin
        #1;
        ce = ce_toggle ? ~ce : 1'b1;
    end

    // Compare process: every clk of an armed transmission.
    always @(negedge clk) begin
        if (active) begin
            cyc++;
            if (ptr < exp_n) begin
                chk("signal", signal, exp_sig[ptr]);
                chk("busy", busy, 1);
                chk("done_early", done, 0);
                if (!signal) mark_clks++;
            end else if (ptr == exp_n) begin
                chk("done", done, 1);
                chk("busy_done", busy, 1);
                chk("signal_done", signal, 1);
                chk("error_done", error, exp_err);
                if (done_cyc == 0) done_cyc = cyc;
            end else begin
                chk("busy_idle", busy, 0);
                chk("done_idle", done, 0);
                chk("signal_idle", signal, 1);
                chk("error_idle", error, exp_err);
                active = 0;
            end
            if (ce) ptr++;
        end
    end

    task automatic arm(input int l, input int d, input int dh, input int wt);
        build(l, d, dh, wt);
        @(posedge clk); #2;
        while (!ce) begin @(posedge clk); #2; end
        for (int i = 0; i < 6; i++) word[i*6 +: 6] = 6'(sl[i]);
        len = 3'(l);
        dit_time = 16'(d); dah_time = 16'(dh); word_time = 16'(wt);
        start = 1;
        @(posedge clk); #2;
        start = 0;
        ptr = 0; cyc = 0; done_cyc = 0; mark_clks = 0;
        active = 1;
    endtask

    task automatic finish_tx(input string nm);
        for (int k = 0; k < 5000 && active; k++) @(posedge clk);
        if (active) begin
            active = 0;
            chk({nm, "_timeout"}, 1, 0);
        end
        @(posedge clk);
    endtask

    task automatic send(input string nm, input int l, input int d, input int dh, input int wt);
        arm(l, d, dh, wt);
        finish_tx(nm);
    endtask

    task automatic set_slots(input int s5, input int s4, input int s3,
                             input int s2, input int s1, input int s0);
        sl[5] = s5; sl[4] = s4; sl[3] = s3; sl[2] = s2; sl[1] = s1; sl[0] = s0;
    endtask

    initial begin
        rst_n = 0; ce = 1; start = 0; word = '0; len = 0;
        dit_time = 2; dah_time = 6; word_time = 14;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_signal", signal, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        @(posedge clk); #2;
        rst_n = 1;

        // Single E: mark t+1..t+2, word gap to t+16, done at t+17.
        set_slots(0, 0, 0, 0, 0, 5);
        send("e", 1, 2, 6, 14);
        chk("e_len", exp_n, 16);
        chk("e_done_cyc", done_cyc, 17);

        // ET: done at t+29.
        set_slots(0, 0, 0, 0, 5, 20);
        send("et", 2, 2, 6, 14);
        chk("et_len", exp_n, 28);
        chk("et_done_cyc", done_cyc, 29);

        // E with ce toggling: 2-pulse mark spans 4 clocks.
        ce_toggle = 1;
        set_slots(0, 0, 0, 0, 0, 5);
        send("e_ce", 1, 2, 6, 14);
        chk("e_ce_mark_clks", mark_clks, 4);
        ce_toggle = 0;

        // Invalid code 40 in slot 1: word gap, error, slot 0 still sent.
        set_slots(0, 0, 0, 0, 40, 5);
        send("inv", 2, 2, 6, 14);
        chk("inv_len", exp_n, 30);
        chk("inv_err_model", exp_err, 1);

        // len = 0 and len = 7: straight to DONE with error.
        send("len0", 0, 2, 6, 14);
        chk("len0_done_cyc", done_cyc, 1);
        set_slots(5, 5, 5, 5, 5, 5);
        send("len7", 7, 2, 6, 14);
        chk("len7_done_cyc", done_cyc, 1);

        // SOS.
        set_slots(0, 0, 0, 19, 15, 19);
        send("sos", 3, 2, 6, 14);
        chk("sos_len", exp_n, 68);

        // Digit, blank, digit.
        set_slots(0, 0, 0, 27, 0, 36);
        send("digits", 3, 1, 3, 7);

        // Zero dit time acts as 1: A = 1 + 1 + 3 + 5.
        set_slots(0, 0, 0, 0, 0, 1);
        send("dit0", 1, 0, 3, 5);
        chk("dit0_len", exp_n, 10);

        // Every valid code.
        for (int w = 0; w < 6; w++) begin
            for (int i = 0; i < 6; i++) sl[i] = w * 6 + 1 + i;
            send("sweep", 6, 1, 2, 3);
        end

        // Reset inside the T mark that follows an invalid slot's word gap.
        set_slots(0, 0, 0, 0, 40, 20);
        arm(2, 2, 6, 14);
        repeat (16) @(posedge clk);
        active = 0;
        @(negedge clk);
        chk("pre_rst_mark", signal, 0);
        chk("pre_rst_error", error, 1);
        @(posedge clk); #2;
        rst_n = 0;
        @(posedge clk); #2;
        rst_n = 1;
        @(negedge clk);
        chk("mid_rst_signal", signal, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_error", error, 0);
        chk("mid_rst_done", done, 0);

        // New start accepted after the reset.
        set_slots(0, 0, 0, 0, 5, 20);
        send("post_rst", 2, 2, 6, 14);
        chk("post_rst_done_cyc", done_cyc, 29);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
